// File: rtl/dift_tpcr_ctrl_if.sv
// CSR-side handshake bundle for the TPCR controller.
// The master (CSR unit) drives the request; the slave (controller) returns ready and read data.
interface dift_tpcr_ctrl_if #(
  parameter int TPCR_WIDTH = 32
);
  logic                  csr_we_i;
  logic [1:0]            csr_op_i;
  logic [TPCR_WIDTH-1:0] csr_wdata_i;
  logic                  csr_ready_o;
  logic [TPCR_WIDTH-1:0] csr_rdata_o;

  modport master (
    output csr_we_i,
    output csr_op_i,
    output csr_wdata_i,
    input  csr_ready_o,
    input  csr_rdata_o
  );

  modport slave (
    input  csr_we_i,
    input  csr_op_i,
    input  csr_wdata_i,
    output csr_ready_o,
    output csr_rdata_o
  );
endinterface

// File: rtl/dift_tpcr_ctrl.sv
// TPCR owner: stages CSR writes in a shadow, stalls issue until EX drains, then commits atomically.
// A committed lock bit freezes the register until reset.
module dift_tpcr_ctrl #(
  parameter int                    TPCR_WIDTH   = 32,
  parameter logic [TPCR_WIDTH-1:0] TPCR_RST_VAL = '0,
  parameter int                    LOCK_BIT     = 31,
  parameter int                    DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dift_tpcr_ctrl_if.slave       csr,
  input  logic                  ex_busy_i,
  output logic                  stall_o,
  output logic [TPCR_WIDTH-1:0] tpcr_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [TPCR_WIDTH-1:0] tpcr_q, tpcr_d;
  logic [TPCR_WIDTH-1:0] shadow_q, shadow_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  locked;
  logic [TPCR_WIDTH-1:0] new_val;

  assign accept = csr.csr_we_i && (state_q == ST_IDLE) && (csr.csr_op_i != OP_NONE);
  assign locked = tpcr_q[LOCK_BIT];

  always_comb begin
    new_val = tpcr_q & ~csr.csr_wdata_i;
    if (csr.csr_op_i == OP_WRITE) begin
      new_val = csr.csr_wdata_i;
    end else if (csr.csr_op_i == OP_SET) begin
      new_val = tpcr_q | csr.csr_wdata_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    tpcr_d   = tpcr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Lock wins over the no-change shortcut: a locked write always reports an error.
          if (locked) begin
            err_d = 1'b1;
          end else if (new_val == tpcr_q) begin
            done_d = 1'b1;
          end else begin
            shadow_d = new_val;
            cnt_d    = 4'd0;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Any busy cycle restarts the window of consecutive idle EX cycles.
        if (ex_busy_i) begin
          cnt_d = 4'd0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_COMMIT: begin
        tpcr_d  = shadow_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tpcr_q   <= TPCR_RST_VAL;
      shadow_q <= TPCR_RST_VAL;
      cnt_q    <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tpcr_q   <= tpcr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign stall_o         = (state_q != ST_IDLE);
  assign csr.csr_ready_o = (state_q == ST_IDLE);
  assign csr.csr_rdata_o = (state_q == ST_IDLE) ? tpcr_q : shadow_q;
  assign tpcr_o          = tpcr_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_dift_tpcr_ctrl.sv
// Randomized bench for dift_tpcr_ctrl: a transaction-level model predicts each write's outcome
// and its commit cycle from the count of consecutive idle EX cycles.
module tb_dift_tpcr_ctrl;
  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_busy;
  logic         stall;
  logic         done;
  logic         err;
  logic [W-1:0] tpcr;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] tpcr_m;

  dift_tpcr_ctrl_if #(.TPCR_WIDTH(W)) csr_if ();

  dift_tpcr_ctrl #(
    .TPCR_WIDTH  (W),
    .TPCR_RST_VAL(32'h0),
    .LOCK_BIT    (31),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .csr      (csr_if.slave),
    .ex_busy_i(ex_busy),
    .stall_o  (stall),
    .tpcr_o   (tpcr),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    csr_if.csr_we_i = 1'b0;
    ex_busy = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    tpcr_m = 32'h0;
    @(negedge clk);
    check("rst_tpcr",  tpcr, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_ready", 32'(csr_if.csr_ready_o), 32'h1);
    check("rst_done",  32'(done), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    $display("txn reset tpcr=%h", tpcr);
  endtask

  // busy_pat gives ex_busy for the first 8 drain cycles; later cycles use busy_pct.
  task automatic do_write(input logic [1:0] op, input logic [W-1:0] wdata,
                          input logic [7:0] busy_pat, input int busy_pct);
    logic [W-1:0] exp_new;
    int streak;
    int cyc;
    string kind;
    @(posedge clk); #1;
    csr_if.csr_we_i    = 1'b1;
    csr_if.csr_op_i    = op;
    csr_if.csr_wdata_i = wdata;
    ex_busy = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_ready", 32'(csr_if.csr_ready_o), 32'h1);
    check("idle_stall", 32'(stall), 32'h0);
    check("idle_rdata", csr_if.csr_rdata_o, tpcr_m);

    case (op)
      2'b01:   exp_new = wdata;
      2'b10:   exp_new = tpcr_m | wdata;
      default: exp_new = tpcr_m & ~wdata;
    endcase

    @(posedge clk); #1;
    if (op == 2'b00 || tpcr_m[31] || exp_new == tpcr_m) begin
      csr_if.csr_we_i = 1'b0;
      @(negedge clk);
      check("short_stall", 32'(stall), 32'h0);
      check("short_tpcr",  tpcr, tpcr_m);
      if (op == 2'b00) begin
        kind = "noop";
        check("noop_done", 32'(done), 32'h0);
        check("noop_err",  32'(err), 32'h0);
      end else if (tpcr_m[31]) begin
        kind = "locked";
        check("lock_err",  32'(err), 32'h1);
        check("lock_done", 32'(done), 32'h0);
      end else begin
        kind = "nochange";
        check("nochg_done", 32'(done), 32'h1);
        check("nochg_err",  32'(err), 32'h0);
      end
    end else begin
      kind = "commit";
      streak = 0;
      cyc = 0;
      forever begin
        // A request held while not ready must be ignored.
        csr_if.csr_we_i    = 1'($urandom_range(0, 1));
        csr_if.csr_op_i    = 2'($urandom_range(1, 3));
        csr_if.csr_wdata_i = $urandom;
        ex_busy = (cyc < 8) ? busy_pat[cyc] : ($urandom_range(0, 99) < busy_pct);
        @(negedge clk);
        check("drain_stall", 32'(stall), 32'h1);
        check("drain_ready", 32'(csr_if.csr_ready_o), 32'h0);
        check("drain_rdata", csr_if.csr_rdata_o, exp_new);
        check("drain_tpcr",  tpcr, tpcr_m);
        check("drain_done",  32'(done), 32'h0);
        streak = ex_busy ? 0 : streak + 1;
        cyc++;
        @(posedge clk); #1;
        if (streak == D) break;
        if (cyc > 200) begin
          check("drain_timeout", 32'(cyc), 32'h0);
          break;
        end
      end
      ex_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("commit_stall", 32'(stall), 32'h1);
      check("commit_rdata", csr_if.csr_rdata_o, exp_new);
      check("commit_tpcr",  tpcr, tpcr_m);
      @(posedge clk); #1;
      csr_if.csr_we_i = 1'b0;
      @(negedge clk);
      check("post_tpcr",  tpcr, exp_new);
      check("post_done",  32'(done), 32'h1);
      check("post_stall", 32'(stall), 32'h0);
      check("post_ready", 32'(csr_if.csr_ready_o), 32'h1);
      tpcr_m = exp_new;
    end
    $display("txn op=%0d wdata=%h kind=%s tpcr=%h", op, wdata, kind, tpcr);
  endtask

  task automatic reset_mid_drain();
    @(posedge clk); #1;
    csr_if.csr_we_i    = 1'b1;
    csr_if.csr_op_i    = 2'b01;
    csr_if.csr_wdata_i = 32'hAA;
    ex_busy = 1'b0;
    @(posedge clk); #1;
    csr_if.csr_we_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tpcr_m = 32'h0;
    @(negedge clk);
    check("mid_stall", 32'(stall), 32'h0);
    check("mid_ready", 32'(csr_if.csr_ready_o), 32'h1);
    check("mid_tpcr",  tpcr, 32'h0);
    check("mid_rdata", csr_if.csr_rdata_o, 32'h0);
    check("mid_done",  32'(done), 32'h0);
    @(negedge clk);
    check("mid_done2", 32'(done), 32'h0);
    check("mid_tpcr2", tpcr, 32'h0);
    $display("txn reset_mid_drain tpcr=%h", tpcr);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] wd;
    rst = 1'b1;
    ex_busy = 1'b0;
    csr_if.csr_we_i    = 1'b0;
    csr_if.csr_op_i    = 2'b00;
    csr_if.csr_wdata_i = '0;
    tpcr_m = 32'h0;

    do_reset();
    do_write(2'b01, 32'h0000_00F0, 8'h00, 0);
    do_reset();
    do_write(2'b01, 32'h0000_00F0, 8'b0000_0011, 0);
    do_write(2'b10, 32'h0000_000F, 8'h00, 0);
    do_write(2'b11, 32'h0000_00F0, 8'h00, 0);
    do_write(2'b10, 32'h0000_000F, 8'h00, 0);
    do_write(2'b00, 32'h1234_5678, 8'h00, 0);
    do_write(2'b01, 32'h8000_0001, 8'b0000_0101, 0);
    do_write(2'b01, 32'h0000_0000, 8'h00, 0);
    do_write(2'b11, 32'h8000_0000, 8'h00, 0);
    do_reset();
    do_write(2'b01, 32'h0000_0005, 8'h00, 0);
    reset_mid_drain();

    for (int i = 0; i < 80; i++) begin
      if (tpcr_m[31] && $urandom_range(0, 3) == 0) do_reset();
      op = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 15) != 0) wd[31] = 1'b0;
      if ($urandom_range(0, 7) == 0) wd = tpcr_m;
      do_write(op, wd, 8'($urandom), 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
